activation_packer: RTL and testbench

- Producer side of the packed output-activation bus feeding the argmax digit predictor.
- Accepts the output layer's activations one neuron per beat over a valid/ready stream and assembles them into one packed, signed vector of neuron_number × resolution bits.
- Presents each completed frame with a valid/ready handshake.
- Double-buffered: the next frame can be collected while the current one is held stable for the predictor.

---
 rtl/activation_packer_pkg.sv | 6 +
 rtl/activation_packer.sv | 109 ++++++++++
 tb/tb_activation_packer.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/activation_packer_pkg.sv
// Shared network dimensions for the output layer, the packer and the argmax predictor.
package activation_packer_pkg;
  localparam int NN_NEURON_NUMBER = 10;
  localparam int NN_RESOLUTION    = 8;
  localparam int NN_COUNT_WIDTH   = 16;
endpackage

// File: rtl/activation_packer.sv
// Collects one activation per beat into a staging buffer and presents complete,
// double-buffered frames to the argmax predictor over a valid/ready handshake.
module activation_packer
  import activation_packer_pkg::*;
#(
  parameter int neuron_number = NN_NEURON_NUMBER,
  parameter int resolution    = NN_RESOLUTION,
  parameter int count_width   = NN_COUNT_WIDTH
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [resolution-1:0]               in_data,
  input  logic                                in_last,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [resolution*neuron_number-1:0] output_activations,
  output logic                                frame_error,
  output logic [count_width-1:0]              frame_count
);

  localparam int CNT_W = (neuron_number > 1) ? $clog2(neuron_number) : 1;
  localparam int VEC_W = resolution * neuron_number;
  localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(neuron_number - 1);

  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   staging_full_q, staging_full_d;
  logic                   out_valid_q, out_valid_d;
  logic                   frame_error_q, frame_error_d;
  logic [count_width-1:0] frame_count_q, frame_count_d;
  logic [VEC_W-1:0]       staging_q, staging_d;
  logic [VEC_W-1:0]       out_q, out_d;

  logic accept, last_slot, complete, out_hs, out_free;

  always_comb begin
    accept    = in_valid && !staging_full_q;
    last_slot = (cnt_q == LAST_SLOT);
    complete  = accept && last_slot;
    out_hs    = out_valid_q && out_ready;
    out_free  = !out_valid_q || out_ready;

    staging_d = staging_q;
    if (accept) begin
      staging_d[int'(cnt_q)*resolution +: resolution] = in_data;
    end

    cnt_d = cnt_q;
    if (accept) begin
      cnt_d = (last_slot || in_last) ? '0 : cnt_q + 1'b1;
    end

    // in_last disagreeing with the slot position is either an early end or a missing end
    frame_error_d = accept && (in_last != last_slot);

    frame_count_d = frame_count_q;
    if (out_hs) begin
      frame_count_d = frame_count_q + 1'b1;
    end

    // staging_d equals staging_q when staging is full, so one load source serves both paths
    staging_full_d = staging_full_q;
    out_valid_d    = out_valid_q;
    out_d          = out_q;
    if (staging_full_q) begin
      if (out_hs) begin
        out_d          = staging_d;
        staging_full_d = 1'b0;
      end
    end else if (complete && out_free) begin
      out_d       = staging_d;
      out_valid_d = 1'b1;
    end else if (complete) begin
      staging_full_d = 1'b1;
    end else if (out_hs) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q          <= '0;
      staging_full_q <= 1'b0;
      out_valid_q    <= 1'b0;
      frame_error_q  <= 1'b0;
      frame_count_q  <= '0;
      out_q          <= '0;
    end else begin
      cnt_q          <= cnt_d;
      staging_full_q <= staging_full_d;
      out_valid_q    <= out_valid_d;
      frame_error_q  <= frame_error_d;
      frame_count_q  <= frame_count_d;
      out_q          <= out_d;
    end
  end

  always_ff @(posedge clk) begin
    staging_q <= staging_d;
  end

  assign in_ready           = !staging_full_q;
  assign out_valid          = out_valid_q;
  assign output_activations = out_q;
  assign frame_error        = frame_error_q;
  assign frame_count        = frame_count_q;

endmodule

// File: tb/tb_activation_packer.sv
// Bench for activation_packer: vector table, directed corner sequences and
// randomized traffic against a frame-queue reference model.
module tb_activation_packer;
  localparam int N  = 10;
  localparam int R  = 8;
  localparam int CW = 16;

  logic          clk;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [R-1:0]  in_data;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [N*R-1:0] output_activations;
  logic          frame_error;
  logic [CW-1:0] frame_count;

  activation_packer dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .output_activations(output_activations),
    .frame_error(frame_error), .frame_count(frame_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Reference model: beats of the frame being collected and the queue of
  // completed frames awaiting the consumer (head is what is presented).
  logic [R-1:0]   beats[$];
  logic [N*R-1:0] fq[$];
  logic [CW-1:0]  m_count;
  logic           m_err;

  typedef struct {
    logic         v;
    logic [R-1:0] d;
    logic         l;
    logic         r;
    logic         e_ov;
    logic         e_ir;
    logic         e_err;
    logic [CW-1:0] e_cnt;
  } vec_t;
  vec_t tbl[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [N*R-1:0] pack_frame();
    logic [N*R-1:0] f;
    f = '0;
    for (int i = 0; i < N; i++) f[i*R +: R] = beats[i];
    return f;
  endfunction

  task automatic model_clear();
    beats.delete();
    fq.delete();
    m_count = '0;
    m_err   = 1'b0;
  endtask

  task automatic compare_model();
    check("m_out_valid", out_valid, fq.size() > 0);
    check("m_in_ready", in_ready, fq.size() < 2);
    check("m_frame_error", frame_error, m_err);
    check("m_frame_count", frame_count, m_count);
    if (fq.size() > 0) check("m_output", output_activations, fq[0]);
  endtask

  task automatic step(input logic v, input logic [R-1:0] d, input logic l, input logic r);
    bit acc, hs;
    in_valid = v; in_data = d; in_last = l; out_ready = r;
    acc = v && (fq.size() < 2);
    hs  = (fq.size() > 0) && r;
    @(posedge clk); #1;
    m_err = 1'b0;
    if (hs) begin
      fq.delete(0);
      m_count++;
    end
    if (acc) begin
      beats.push_back(d);
      if (beats.size() == N) begin
        fq.push_back(pack_frame());
        m_err = !l;
        beats.delete();
      end else if (l) begin
        m_err = 1'b1;
        beats.delete();
      end
    end
    compare_model();
  endtask

  task automatic send_frame(input logic [R-1:0] base, input logic r);
    for (int i = 0; i < N; i++) step(1'b1, base + R'(i), i == N - 1, r);
  endtask

  task automatic async_reset(input string tag);
    #2 reset = 1'b1;
    in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    #1;
    check({tag, "_out_valid"}, out_valid, 1'b0);
    check({tag, "_in_ready"}, in_ready, 1'b1);
    check({tag, "_output"}, output_activations, '0);
    check({tag, "_count"}, frame_count, '0);
    check({tag, "_err"}, frame_error, 1'b0);
    model_clear();
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  function automatic void add(input logic v, input logic [R-1:0] d, input logic l, input logic r,
                              input logic ov, input logic ir, input logic er, input logic [CW-1:0] c);
    vec_t t;
    t.v = v; t.d = d; t.l = l; t.r = r; t.e_ov = ov; t.e_ir = ir; t.e_err = er; t.e_cnt = c;
    tbl.push_back(t);
  endfunction

  initial begin
    logic [R-1:0] nom[N];
    int ov_seen;
    int ir_drop;
    nom = '{8'h03, 8'hFB, 8'h07, 8'h00, 8'h0C, 8'h80, 8'h7F, 8'h01, 8'h02, 8'h09};
    for (int i = 0; i < N; i++) add(1'b1, nom[i], i == N - 1, 1'b1, i == N - 1, 1'b1, 1'b0, 16'd0);
    add(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'd1);
    for (int i = 0; i < 4; i++) add(1'b1, 8'hA0 + R'(i), i == 3, 1'b1, 1'b0, 1'b1, i == 3, 16'd1);
    add(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'd1);

    reset = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_output", output_activations, '0);
    check("rst_count", frame_count, '0);
    check("rst_err", frame_error, 1'b0);
    reset = 1'b0;

    // Nominal frame, its handshake, and an early in_last abort
    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].v, tbl[i].d, tbl[i].l, tbl[i].r);
      check("tbl_out_valid", out_valid, tbl[i].e_ov);
      check("tbl_in_ready", in_ready, tbl[i].e_ir);
      check("tbl_frame_error", frame_error, tbl[i].e_err);
      check("tbl_frame_count", frame_count, tbl[i].e_cnt);
      if (i == N - 1) begin
        check("nom_neuron6", output_activations[6*R +: R], 8'h7F);
        check("nom_neuron5", output_activations[5*R +: R], 8'h80);
        check("nom_neuron1", output_activations[1*R +: R], 8'hFB);
      end
    end

    // Frame after the early abort starts at neuron 0
    send_frame(8'h10, 1'b0);
    check("post_abort_valid", out_valid, 1'b1);
    check("post_abort_n0", output_activations[0 +: R], 8'h10);
    check("post_abort_n9", output_activations[9*R +: R], 8'h19);
    step(1'b0, 8'h00, 1'b0, 1'b1);

    // Backpressure: A held, B staged, then swapped in by one handshake
    send_frame(8'h20, 1'b0);
    send_frame(8'h40, 1'b0);
    check("bp_in_ready_low", in_ready, 1'b0);
    check("bp_hold_a", output_activations[0 +: R], 8'h20);
    step(1'b1, 8'h55, 1'b0, 1'b0);
    check("bp_still_a", output_activations[0 +: R], 8'h20);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    check("bp_valid_kept", out_valid, 1'b1);
    check("bp_swap_b", output_activations[0 +: R], 8'h40);
    check("bp_in_ready_back", in_ready, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    check("bp_drained", out_valid, 1'b0);

    // Missing in_last on the tenth beat
    for (int i = 0; i < N; i++) step(1'b1, 8'h60 + R'(i), 1'b0, 1'b0);
    check("miss_valid", out_valid, 1'b1);
    check("miss_err", frame_error, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    check("miss_err_pulse", frame_error, 1'b0);

    // Reset after beat 5, then a clean frame
    for (int i = 0; i < 5; i++) step(1'b1, 8'h70 + R'(i), 1'b0, 1'b1);
    async_reset("rst_mid_frame");
    send_frame(8'h30, 1'b0);
    check("rst_frame_n0", output_activations[0 +: R], 8'h30);

    // Reset while a frame is held and another staged
    send_frame(8'h90, 1'b0);
    async_reset("rst_mid_hold");
    send_frame(8'hC0, 1'b1);
    check("rst2_frame_n3", output_activations[3*R +: R], 8'hC3);
    step(1'b0, 8'h00, 1'b0, 1'b1);

    // Throughput: three back-to-back frames with the consumer always ready
    async_reset("rst_thru");
    ov_seen = 0; ir_drop = 0;
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < N; i++) begin
        step(1'b1, R'(f * 16 + i), i == N - 1, 1'b1);
        if (out_valid) ov_seen++;
        if (!in_ready) ir_drop++;
      end
    end
    step(1'b0, 8'h00, 1'b0, 1'b1);
    if (out_valid) ov_seen++;
    check("thru_valid_beats", ov_seen, 3);
    check("thru_no_stall", ir_drop, 0);
    check("thru_count", frame_count, 3);

    // Randomized traffic against the model
    for (int c = 0; c < 1500; c++) begin
      logic v, l, r;
      v = ($urandom_range(0, 9) < 7);
      r = ($urandom_range(0, 1) == 1);
      if (beats.size() == N - 1) l = ($urandom_range(0, 9) != 0);
      else l = ($urandom_range(0, 39) == 0);
      step(v, R'($urandom), l, r);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
